// File: rtl/qbus_arb_pkg.sv
// Shared types and width helpers for the Q-bus DMA arbiter.
package qbus_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_GRANT,
        ST_OWNED,
        ST_RELEASE
    } arb_state_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/qbus_rr_pick.sv
// Combinational round-robin picker: first active request after i_last, wrapping.
module qbus_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic [IW-1:0]   o_idx,
    output logic            o_vld
);

    logic [IW-1:0] w_cand;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        o_idx  = '0;
        o_vld  = 1'b0;
        w_cand = '0;
        // Walk from the farthest offset inward so the nearest requester is the last to write.
        for (int k = NREQ; k >= 1; k--) begin
            w_cand = IW'((int'(i_last) + k) % NREQ);
            if (i_req[w_cand]) begin
                o_idx = w_cand;
                o_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qbus_dma_arbiter.sv
// Q-bus DMA bus-mastership arbiter: holds off the CPU, grants DMGO round-robin,
// tracks the SACK handshake and withdraws an unanswered grant after GTMO cycles.
module qbus_dma_arbiter
    import qbus_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int GTMO = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         dmr_i,
    input  logic [NREQ-1:0]         sack_i,
    input  logic                    cpu_busy_i,
    output logic                    cpu_hold_o,
    output logic [NREQ-1:0]         dmgo_o,
    output logic [$clog2(NREQ)-1:0] owner_o,
    output logic                    owner_vld_o,
    output logic                    tmo_o
);

    localparam int OW = $clog2(NREQ);
    localparam int CW = width_of(GTMO + 1);

    arb_state_t      r_state;
    logic            r_hold;
    logic [NREQ-1:0] r_dmgo;
    logic [OW-1:0]   r_owner;
    logic [OW-1:0]   r_last;
    logic            r_vld;
    logic            r_tmo;
    logic [CW-1:0]   r_cnt;

    logic [OW-1:0]   w_pick_idx;
    logic            w_pick_vld;

    qbus_rr_pick #(
        .NREQ (NREQ),
        .IW   (OW)
    ) u_pick (
        .i_req  (dmr_i),
        .i_last (r_last),
        .o_idx  (w_pick_idx),
        .o_vld  (w_pick_vld)
    );

    // NOTE: sequential state uses non-blocking assignments only; every register has a reset value,
    // so an rst pulse always drops dmgo_o on the next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_hold  <= 1'b0;
            r_dmgo  <= '0;
            r_owner <= '0;
            r_last  <= OW'(NREQ - 1);
            r_vld   <= 1'b0;
            r_tmo   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_tmo <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|dmr_i) begin
                        r_state <= ST_HOLD;
                        r_hold  <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    // Only arbitrate once the CPU has finished its bus cycle.
                    if (!cpu_busy_i) begin
                        if (w_pick_vld) begin
                            r_state <= ST_GRANT;
                            r_owner <= w_pick_idx;
                            r_dmgo  <= NREQ'(1) << w_pick_idx;
                            r_cnt   <= CW'(1);
                        end else begin
                            r_state <= ST_IDLE;
                            r_hold  <= 1'b0;
                        end
                    end
                end
                ST_GRANT: begin
                    if (sack_i[r_owner]) begin
                        r_state <= ST_OWNED;
                        r_dmgo  <= '0;
                        r_vld   <= 1'b1;
                        r_last  <= r_owner;
                    end else if (!dmr_i[r_owner]) begin
                        r_state <= ST_IDLE;
                        r_dmgo  <= '0;
                        r_hold  <= 1'b0;
                        r_last  <= r_owner;
                    end else if (r_cnt == CW'(GTMO)) begin
                        r_state <= ST_IDLE;
                        r_dmgo  <= '0;
                        r_hold  <= 1'b0;
                        r_last  <= r_owner;
                        r_tmo   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_OWNED: begin
                    if (!sack_i[r_owner]) begin
                        r_state <= ST_RELEASE;
                        r_vld   <= 1'b0;
                    end
                end
                ST_RELEASE: begin
                    r_state <= ST_IDLE;
                    r_hold  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_hold  <= 1'b0;
                    r_dmgo  <= '0;
                    r_vld   <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_hold_o  = r_hold;
    assign dmgo_o      = r_dmgo;
    assign owner_o     = r_owner;
    assign owner_vld_o = r_vld;
    assign tmo_o       = r_tmo;

endmodule

// File: tb/tb_qbus_dma_arbiter.sv
// Self-checking bench for qbus_dma_arbiter: directed scenarios plus random traffic
// compared every cycle against a bus-ownership reference model.
module tb_qbus_dma_arbiter;

    localparam int NREQ = 4;
    localparam int GTMO = 15;

    logic            clk;
    logic            rst;
    logic [NREQ-1:0] dmr_i;
    logic [NREQ-1:0] sack_i;
    logic            cpu_busy_i;
    logic            cpu_hold_o;
    logic [NREQ-1:0] dmgo_o;
    logic [1:0]      owner_o;
    logic            owner_vld_o;
    logic            tmo_o;

    int n_checks = 0;
    int n_fail   = 0;

    qbus_dma_arbiter #(
        .NREQ (NREQ),
        .GTMO (GTMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dmr_i       (dmr_i),
        .sack_i      (sack_i),
        .cpu_busy_i  (cpu_busy_i),
        .cpu_hold_o  (cpu_hold_o),
        .dmgo_o      (dmgo_o),
        .owner_o     (owner_o),
        .owner_vld_o (owner_vld_o),
        .tmo_o       (tmo_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: who is being offered the bus, who owns it, and whether the CPU is held off.
    bit m_hold;
    bit m_rel;
    bit m_tmo;
    int m_grant;
    int m_own;
    int m_age;
    int m_last;
    int m_owner;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_winner(input logic [NREQ-1:0] req, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (req[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int lowest_set(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_hold  = 1'b0;
        m_rel   = 1'b0;
        m_tmo   = 1'b0;
        m_grant = -1;
        m_own   = -1;
        m_age   = 0;
        m_last  = NREQ - 1;
        m_owner = 0;
    endtask

    task automatic model_step(input logic [NREQ-1:0] dmr, input logic [NREQ-1:0] sack,
                              input logic busy, input logic r);
        int w;
        if (r) begin
            model_reset();
            return;
        end
        m_tmo = 1'b0;
        if (m_grant >= 0) begin
            m_last = m_grant;
            if (sack[m_grant]) begin
                m_own   = m_grant;
                m_grant = -1;
            end else if (!dmr[m_grant]) begin
                m_grant = -1;
                m_hold  = 1'b0;
            end else if (m_age == GTMO) begin
                m_grant = -1;
                m_hold  = 1'b0;
                m_tmo   = 1'b1;
            end else begin
                m_age++;
                m_last = -1;
            end
            if (m_last < 0) m_last = m_owner;
        end else if (m_own >= 0) begin
            if (!sack[m_own]) begin
                m_own = -1;
                m_rel = 1'b1;
            end
        end else if (m_rel) begin
            m_rel  = 1'b0;
            m_hold = 1'b0;
        end else if (m_hold) begin
            if (!busy) begin
                w = rr_winner(dmr, m_last);
                if (w < 0) begin
                    m_hold = 1'b0;
                end else begin
                    m_grant = w;
                    m_owner = w;
                    m_age   = 1;
                end
            end
        end else if (dmr != '0) begin
            m_hold = 1'b1;
        end
    endtask

    // Apply one cycle of inputs, advance the model on the edge, compare on the falling edge.
    task automatic tick(input logic [NREQ-1:0] dmr, input logic [NREQ-1:0] sack,
                        input logic busy, input logic r);
        logic [NREQ-1:0] exp_dmgo;
        dmr_i      = dmr;
        sack_i     = sack;
        cpu_busy_i = busy;
        rst        = r;
        @(posedge clk);
        model_step(dmr, sack, busy, r);
        @(negedge clk);
        exp_dmgo = (m_grant >= 0) ? NREQ'(1 << m_grant) : '0;
        check("cpu_hold", 32'(cpu_hold_o), 32'(m_hold));
        check("dmgo", 32'(dmgo_o), 32'(exp_dmgo));
        check("owner", 32'(owner_o), 32'(m_owner));
        check("owner_vld", 32'(owner_vld_o), 32'(m_own >= 0));
        check("tmo", 32'(tmo_o), 32'(m_tmo));
    endtask

    initial begin
        int got;
        int n_dm;
        int n_tmo;
        logic [NREQ-1:0] s;
        logic [NREQ-1:0] d;
        logic [NREQ-1:0] sk;
        logic b;
        logic r;

        model_reset();
        dmr_i = '0; sack_i = '0; cpu_busy_i = 1'b0; rst = 1'b1;

        // Reset state
        tick(4'b0000, 4'b0000, 1'b0, 1'b1);
        tick(4'b0000, 4'b0000, 1'b0, 1'b1);
        check("rst_hold", 32'(cpu_hold_o), 32'd0);
        check("rst_dmgo", 32'(dmgo_o), 32'd0);
        check("rst_owner", 32'(owner_o), 32'd0);

        // Single request through the full handshake
        tick(4'b0010, 4'b0000, 1'b0, 1'b0);
        check("single_hold", 32'(cpu_hold_o), 32'd1);
        check("single_nogrant", 32'(dmgo_o), 32'd0);
        tick(4'b0010, 4'b0000, 1'b0, 1'b0);
        check("single_grant", 32'(dmgo_o), 32'b0010);
        tick(4'b0010, 4'b0010, 1'b0, 1'b0);
        check("single_owner", 32'(owner_o), 32'd1);
        check("single_vld", 32'(owner_vld_o), 32'd1);
        tick(4'b0000, 4'b0000, 1'b0, 1'b0);
        check("single_rel_hold", 32'(cpu_hold_o), 32'd1);
        tick(4'b0000, 4'b0000, 1'b0, 1'b0);
        check("single_idle_hold", 32'(cpu_hold_o), 32'd0);

        // CPU busy blocks the grant
        for (int c = 0; c < 5; c++) begin
            tick(4'b0001, 4'b0000, 1'b1, 1'b0);
            check("busy_hold", 32'(cpu_hold_o), 32'd1);
            check("busy_nogrant", 32'(dmgo_o), 32'd0);
        end
        tick(4'b0001, 4'b0000, 1'b0, 1'b0);
        check("busy_grant", 32'(dmgo_o), 32'b0001);
        tick(4'b0001, 4'b0001, 1'b0, 1'b0);
        tick(4'b0000, 4'b0000, 1'b0, 1'b0);
        tick(4'b0000, 4'b0000, 1'b0, 1'b0);

        // Round-robin with all requesters active and non-owner SACK noise
        tick(4'b0000, 4'b0000, 1'b0, 1'b1);
        for (int w = 0; w < 5; w++) begin
            got = -1;
            for (int c = 0; c < 8 && got < 0; c++) begin
                tick(4'b1111, 4'b0000, 1'b0, 1'b0);
                got = lowest_set(dmgo_o);
            end
            check("rr_order", 32'(got), 32'(w % NREQ));
            if (got >= 0) begin
                s = NREQ'(1 << got);
                tick(4'b1111, s, 1'b0, 1'b0);
                s = NREQ'((1 << got) | (1 << ((got + 1) % NREQ)));
                tick(4'b1111, s, 1'b0, 1'b0);
                check("rr_owned", 32'(owner_vld_o), 32'd1);
                s = NREQ'(1 << ((got + 1) % NREQ));
                tick(4'b1111, s, 1'b0, 1'b0);
                check("rr_released", 32'(owner_vld_o), 32'd0);
            end
        end

        // Timeout with no SACK
        n_dm  = 0;
        n_tmo = 0;
        for (int c = 0; c < 40 && n_tmo == 0; c++) begin
            tick(4'b0100, 4'b0000, 1'b0, 1'b0);
            if (dmgo_o != '0) n_dm++;
            if (tmo_o) begin
                n_tmo++;
                check("tmo_dmgo_low", 32'(dmgo_o), 32'd0);
            end
        end
        check("tmo_len", 32'(n_dm), 32'(GTMO));
        check("tmo_seen", 32'(n_tmo), 32'd1);
        tick(4'b0110, 4'b0000, 1'b0, 1'b0);
        check("tmo_single_pulse", 32'(tmo_o), 32'd0);
        got = -1;
        for (int c = 0; c < 8 && got < 0; c++) begin
            tick(4'b0110, 4'b0000, 1'b0, 1'b0);
            got = lowest_set(dmgo_o);
        end
        check("tmo_next_winner", 32'(got), 32'd1);

        // Withdrawal during GRANT
        tick(4'b0000, 4'b0000, 1'b0, 1'b0);
        check("wd_dmgo", 32'(dmgo_o), 32'd0);
        check("wd_tmo", 32'(tmo_o), 32'd0);
        check("wd_hold", 32'(cpu_hold_o), 32'd0);

        // Reset while OWNED
        got = -1;
        for (int c = 0; c < 8 && got < 0; c++) begin
            tick(4'b1000, 4'b0000, 1'b0, 1'b0);
            got = lowest_set(dmgo_o);
        end
        check("ro_grant", 32'(got), 32'd3);
        tick(4'b1000, 4'b1000, 1'b0, 1'b0);
        check("ro_owned", 32'(owner_vld_o), 32'd1);
        tick(4'b1000, 4'b1000, 1'b0, 1'b1);
        check("ro_rst_vld", 32'(owner_vld_o), 32'd0);
        check("ro_rst_owner", 32'(owner_o), 32'd0);
        check("ro_rst_hold", 32'(cpu_hold_o), 32'd0);
        got = -1;
        for (int c = 0; c < 8 && got < 0; c++) begin
            tick(4'b1111, 4'b0000, 1'b0, 1'b0);
            got = lowest_set(dmgo_o);
        end
        check("ro_next_winner", 32'(got), 32'd0);

        // Random traffic against the model
        d = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) d = NREQ'($urandom_range(0, 15));
            b  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 299) == 0);
            sk = ($urandom_range(0, 7) == 0) ? NREQ'($urandom_range(0, 15)) : '0;
            if (m_grant >= 0 && $urandom_range(0, 5) == 0) sk[m_grant] = 1'b1;
            if (m_own >= 0 && $urandom_range(0, 3) != 0) sk[m_own] = 1'b1;
            tick(d, sk, b, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
